// File: rtl/fd_seg_pkg.sv
// Shared seven-segment definitions for the tick counter display: digit type,
// active-low segment codes and the blank pattern.
package fd_seg_pkg;

  localparam int SEG_W = 7;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}; a lit segment is driven low.
  localparam logic [SEG_W-1:0] SEG_LUT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking.
module seg7_decode
  import fd_seg_pkg::*;
(
  input  bcd_digit_t       digit,
  input  logic             blank,
  output logic [SEG_W-1:0] segments
);

  always_comb begin
    segments = SEG_BLANK;
    if (!blank && (digit <= 4'd9)) begin
      segments = SEG_LUT[digit];
    end
  end

endmodule

// File: rtl/tick_bcd_display.sv
// Counts divider ticks as a multi-digit BCD value with run/up-down/clear control
// and drives registered active-low HEX displays plus wrap/overflow flags.
module tick_bcd_display
  import fd_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int WRAP_MODE     = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    tick_en,
  input  logic                    run,
  input  logic                    up_dn,
  input  logic                    clear,
  output logic [NUM_DIGITS*4-1:0] bcd,
  output logic                    wrap,
  output logic                    ovf,
  output logic [SEG_W-1:0]        HEX0,
  output logic [SEG_W-1:0]        HEX1,
  output logic [SEG_W-1:0]        HEX2,
  output logic [SEG_W-1:0]        HEX3,
  output logic [SEG_W-1:0]        HEX4,
  output logic [SEG_W-1:0]        HEX5
);

  localparam int BCD_W = NUM_DIGITS * 4;

  logic [BCD_W-1:0]                  bcd_q, bcd_d;
  logic                              wrap_q, wrap_d;
  logic                              ovf_q, ovf_d;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]  hex_q, hex_d;
  logic [NUM_DIGITS-1:0]             blank;

  // A carry/borrow surviving past the top digit means the count sat at its limit.
  always_comb begin : count_next
    logic [BCD_W-1:0] stepped;
    logic             carry;
    bcd_digit_t       dig;
    stepped = bcd_q;
    carry   = 1'b1;
    dig     = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dig = bcd_q[4*k +: 4];
      if (carry) begin
        if (up_dn) begin
          if (dig == 4'd9) begin
            stepped[4*k +: 4] = 4'd0;
          end else begin
            stepped[4*k +: 4] = dig + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            stepped[4*k +: 4] = 4'd9;
          end else begin
            stepped[4*k +: 4] = dig - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end

    bcd_d  = bcd_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    if (clear) begin
      bcd_d = '0;
      ovf_d = 1'b0;
    end else if (tick_en && run) begin
      if (!carry) begin
        bcd_d = stepped;
      end else if (WRAP_MODE != 0) begin
        bcd_d  = stepped;
        wrap_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // A digit blanks only when it and every digit above it are zero.
  always_comb begin : leading_blank
    logic zero_run;
    zero_run = 1'b1;
    blank    = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (bcd_q[4*k +: 4] == 4'd0);
      blank[k] = (BLANK_LEADING != 0) && zero_run;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_decode
    seg7_decode u_dec (
      .digit    (bcd_q[4*g +: 4]),
      .blank    (blank[g]),
      .segments (hex_d[g])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bcd_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        hex_q[k] <= ((k == 0) || (BLANK_LEADING == 0)) ? SEG_LUT[0] : SEG_BLANK;
      end
    end else begin
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
      hex_q  <= hex_d;
    end
  end

  assign bcd  = bcd_q;
  assign wrap = wrap_q;
  assign ovf  = (WRAP_MODE == 0) ? ovf_q : 1'b0;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_tick_bcd_display.sv
// Directed bench for tick_bcd_display: a wrapping/blanking instance and a
// saturating/unblanked instance share one stimulus stream.
module tb_tick_bcd_display;

  logic        clk;
  logic        reset;
  logic        tick_en;
  logic        run;
  logic        up_dn;
  logic        clear;

  logic [23:0] bcd, bcd_s;
  logic        wrap, wrap_s, ovf, ovf_s;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [6:0]  hex0_s, hex1_s, hex2_s, hex3_s, hex4_s, hex5_s;

  int n_vec = 0;
  int n_err = 0;

  tick_bcd_display #(.NUM_DIGITS(6), .WRAP_MODE(1), .BLANK_LEADING(1)) dut (
    .CLOCK_50(clk), .reset(reset), .tick_en(tick_en), .run(run),
    .up_dn(up_dn), .clear(clear), .bcd(bcd), .wrap(wrap), .ovf(ovf),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5)
  );

  tick_bcd_display #(.NUM_DIGITS(6), .WRAP_MODE(0), .BLANK_LEADING(0)) dut_sat (
    .CLOCK_50(clk), .reset(reset), .tick_en(tick_en), .run(run),
    .up_dn(up_dn), .clear(clear), .bcd(bcd_s), .wrap(wrap_s), .ovf(ovf_s),
    .HEX0(hex0_s), .HEX1(hex1_s), .HEX2(hex2_s), .HEX3(hex3_s), .HEX4(hex4_s), .HEX5(hex5_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, return at the next falling edge.
  task automatic applyStimulus(input logic te, input logic rn, input logic ud, input logic cl);
    tick_en = te;
    run     = rn;
    up_dn   = ud;
    clear   = cl;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; tick_en = 1'b0; run = 1'b0; up_dn = 1'b1; clear = 1'b0;
    @(negedge clk);
    applyStimulus(1, 1, 1, 0);
    checkOutput("rst_bcd",    {8'h0, bcd}, 32'h0);
    checkOutput("rst_wrap",   {31'h0, wrap}, 32'h0);
    checkOutput("rst_ovf_s",  {31'h0, ovf_s}, 32'h0);
    checkOutput("rst_hex0",   {25'h0, hex0}, 32'h40);
    checkOutput("rst_hex1",   {25'h0, hex1}, 32'h7F);
    checkOutput("rst_hex5",   {25'h0, hex5}, 32'h7F);
    checkOutput("rst_hex5_s", {25'h0, hex5_s}, 32'h40);
    reset = 1'b0;

    // Twelve up ticks
    repeat (12) applyStimulus(1, 1, 1, 0);
    checkOutput("t1_bcd",   {8'h0, bcd}, 32'h000012);
    checkOutput("t1_bcd_s", {8'h0, bcd_s}, 32'h000012);
    applyStimulus(0, 1, 1, 0);
    checkOutput("t1_hex0",   {25'h0, hex0}, 32'h24);
    checkOutput("t1_hex1",   {25'h0, hex1}, 32'h79);
    checkOutput("t1_hex2",   {25'h0, hex2}, 32'h7F);
    checkOutput("t1_hex5",   {25'h0, hex5}, 32'h7F);
    checkOutput("t1_hex2_s", {25'h0, hex2_s}, 32'h40);

    // Down from zero: wrap vs saturate
    applyStimulus(0, 1, 1, 1);
    checkOutput("clr_bcd", {8'h0, bcd}, 32'h0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("t3_bcd",    {8'h0, bcd}, 32'h999999);
    checkOutput("t3_wrap",   {31'h0, wrap}, 32'h1);
    checkOutput("t3_bcd_s",  {8'h0, bcd_s}, 32'h0);
    checkOutput("t3_ovf_s",  {31'h0, ovf_s}, 32'h1);
    checkOutput("t3_wrap_s", {31'h0, wrap_s}, 32'h0);
    checkOutput("t3_ovf",    {31'h0, ovf}, 32'h0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("t3_wrap_end", {31'h0, wrap}, 32'h0);
    checkOutput("t3_hex0",     {25'h0, hex0}, 32'h10);
    checkOutput("t3_hex3",     {25'h0, hex3}, 32'h10);
    checkOutput("t3_hex5",     {25'h0, hex5}, 32'h10);

    // Preload 999998 then two up ticks across the top
    applyStimulus(1, 1, 0, 0);
    checkOutput("t2_pre",     {8'h0, bcd}, 32'h999998);
    checkOutput("t2_pre_s",   {8'h0, bcd_s}, 32'h0);
    applyStimulus(1, 1, 1, 0);
    checkOutput("t2_bcd1",    {8'h0, bcd}, 32'h999999);
    checkOutput("t2_wrap1",   {31'h0, wrap}, 32'h0);
    checkOutput("t2_away_s",  {8'h0, bcd_s}, 32'h000001);
    checkOutput("t2_ovf_s",   {31'h0, ovf_s}, 32'h1);
    applyStimulus(1, 1, 1, 0);
    checkOutput("t2_bcd2",    {8'h0, bcd}, 32'h0);
    checkOutput("t2_wrap2",   {31'h0, wrap}, 32'h1);
    applyStimulus(0, 1, 1, 0);
    checkOutput("t2_wrap_end", {31'h0, wrap}, 32'h0);
    checkOutput("t2_hex0",     {25'h0, hex0}, 32'h40);
    checkOutput("t2_hex1",     {25'h0, hex1}, 32'h7F);
    checkOutput("t2_hex5",     {25'h0, hex5}, 32'h7F);

    // Hold with run low, then clear beats a simultaneous tick
    applyStimulus(0, 1, 1, 1);
    checkOutput("t4_clr_ovf_s", {31'h0, ovf_s}, 32'h0);
    repeat (5) applyStimulus(1, 1, 1, 0);
    checkOutput("t4_five", {8'h0, bcd}, 32'h000005);
    repeat (10) applyStimulus(1, 0, 1, 0);
    checkOutput("t4_hold", {8'h0, bcd}, 32'h000005);
    applyStimulus(1, 1, 0, 0);
    checkOutput("t4_dn", {8'h0, bcd}, 32'h000004);
    applyStimulus(1, 1, 1, 0);
    checkOutput("t4_up", {8'h0, bcd}, 32'h000005);
    applyStimulus(1, 1, 1, 1);
    checkOutput("t4_clr_bcd",   {8'h0, bcd}, 32'h0);
    checkOutput("t4_clr_bcd_s", {8'h0, bcd_s}, 32'h0);
    checkOutput("t4_clr_ovf_s2", {31'h0, ovf_s}, 32'h0);

    // Back-to-back ticks
    repeat (1000) applyStimulus(1, 1, 1, 0);
    checkOutput("t5_bcd",   {8'h0, bcd}, 32'h001000);
    checkOutput("t5_bcd_s", {8'h0, bcd_s}, 32'h001000);
    applyStimulus(0, 1, 1, 0);
    checkOutput("t5_hex0", {25'h0, hex0}, 32'h40);
    checkOutput("t5_hex2", {25'h0, hex2}, 32'h40);
    checkOutput("t5_hex3", {25'h0, hex3}, 32'h79);
    checkOutput("t5_hex4", {25'h0, hex4}, 32'h7F);
    checkOutput("t5_hex5", {25'h0, hex5}, 32'h7F);

    // Reset in the middle of a count
    applyStimulus(0, 1, 1, 1);
    repeat (437) applyStimulus(1, 1, 1, 0);
    checkOutput("t6_bcd", {8'h0, bcd}, 32'h000437);
    applyStimulus(0, 1, 1, 0);
    checkOutput("t6_hex0", {25'h0, hex0}, 32'h78);
    checkOutput("t6_hex1", {25'h0, hex1}, 32'h30);
    checkOutput("t6_hex2", {25'h0, hex2}, 32'h19);
    checkOutput("t6_hex3", {25'h0, hex3}, 32'h7F);
    reset = 1'b1;
    applyStimulus(1, 1, 1, 0);
    reset = 1'b0;
    checkOutput("t6_rst_bcd",  {8'h0, bcd}, 32'h0);
    checkOutput("t6_rst_hex0", {25'h0, hex0}, 32'h40);
    checkOutput("t6_rst_hex1", {25'h0, hex1}, 32'h7F);
    applyStimulus(0, 1, 1, 0);
    checkOutput("t6_idle_hex2", {25'h0, hex2}, 32'h7F);
    applyStimulus(1, 1, 1, 0);
    checkOutput("t6_resume", {8'h0, bcd}, 32'h000001);
    applyStimulus(0, 1, 1, 0);
    checkOutput("t6_resume_hex0", {25'h0, hex0}, 32'h79);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
